adder_axi_master: RTL and testbench



---
 rtl/adder_axi_pkg.sv | 23 ++
 rtl/adder_axi_wdog.sv | 36 +++
 rtl/adder_axi_master.sv | 177 +++++++++++++++++
 tb/tb_adder_axi_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_axi_pkg.sv
// Shared types and register map for the adder AXI4-Lite master.
package adder_axi_pkg;

   typedef enum logic [3:0] {
      IDLE,
      WR_A,
      WR_A_B,
      WR_B,
      WR_B_B,
      RD_SUM,
      RD_SUM_R,
      RD_OVF,
      RD_OVF_R,
      DONE
   } state_t;

   localparam int unsigned ADDR_OPA  = 32'h00;
   localparam int unsigned ADDR_OPB  = 32'h04;
   localparam int unsigned ADDR_SUM  = 32'h08;
   localparam int unsigned ADDR_OVF  = 32'h0C;
   localparam int unsigned RESP_OKAY = 0;

endpackage

// File: rtl/adder_axi_wdog.sv
// Handshake watchdog: counts cycles spent in the current wait state.
module adder_axi_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // restart loads 1 so the count equals cycles spent in the new state
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = CW'(1);
      end else if (enable && !expired) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adder_axi_master.sv
// AXI4-Lite master: writes two operands to the adder slave, reads back sum/overflow.
module adder_axi_master
   import adder_axi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned RESP_WIDTH     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    m1_axi_aclk,
   input  logic                    m1_axi_areset,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   sum,
   output logic                    overflow,
   output logic                    error,
   output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   output logic                    m1_axi_awvalid,
   input  logic                    m1_axi_awready,
   output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
   output logic                    m1_axi_wvalid,
   input  logic                    m1_axi_wready,
   input  logic [RESP_WIDTH-1:0]   m1_axi_bresp,
   input  logic                    m1_axi_bvalid,
   output logic                    m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   output logic                    m1_axi_arvalid,
   input  logic                    m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   input  logic [RESP_WIDTH-1:0]   m1_axi_rresp,
   input  logic                    m1_axi_rvalid,
   output logic                    m1_axi_rready
);

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   opa_q, opa_d;
   logic [DATA_WIDTH-1:0]   opb_q, opb_d;
   logic [DATA_WIDTH-1:0]   sum_q, sum_d;
   logic                    ovf_q, ovf_d;
   logic                    err_q, err_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    wr_st, wrb_st, rd_st, rdr_st;
   logic                    wait_st, is_sum, take_r;
   logic                    restart, expired;

   assign wr_st   = (state_q == WR_A) || (state_q == WR_B);
   assign wrb_st  = (state_q == WR_A_B) || (state_q == WR_B_B);
   assign rd_st   = (state_q == RD_SUM) || (state_q == RD_OVF);
   assign rdr_st  = (state_q == RD_SUM_R) || (state_q == RD_OVF_R);
   assign wait_st = (state_q != IDLE) && (state_q != DONE);
   assign is_sum  = (state_q == RD_SUM) || (state_q == RD_SUM_R);
   assign restart = (state_d != state_q);

   adder_axi_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (m1_axi_aclk),
      .rst    (m1_axi_areset),
      .restart(restart),
      .enable (wait_st),
      .expired(expired)
   );

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      sum_d     = sum_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      take_r    = 1'b0;
      // a stalled handshake is abandoned outright, valids drop with it
      if (wait_st && expired) begin
         state_d = DONE;
         err_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  opa_d   = op_a;
                  opb_d   = op_b;
                  err_d   = 1'b0;
                  state_d = WR_A;
               end
            end
            WR_A, WR_B: begin
               if (m1_axi_awvalid && m1_axi_awready) aw_done_d = 1'b1;
               if (m1_axi_wvalid && m1_axi_wready) w_done_d = 1'b1;
               if (aw_done_d && w_done_d) begin
                  state_d = (state_q == WR_A) ? WR_A_B : WR_B_B;
               end
            end
            WR_A_B, WR_B_B: begin
               if (m1_axi_bvalid) begin
                  if (m1_axi_bresp != RESP_WIDTH'(RESP_OKAY)) err_d = 1'b1;
                  state_d = (state_q == WR_A_B) ? WR_B : RD_SUM;
               end
            end
            RD_SUM, RD_OVF: begin
               if (m1_axi_arready) begin
                  take_r = m1_axi_rvalid;
                  if (m1_axi_rvalid) begin
                     state_d = is_sum ? RD_OVF : DONE;
                  end else begin
                     state_d = is_sum ? RD_SUM_R : RD_OVF_R;
                  end
               end
            end
            RD_SUM_R, RD_OVF_R: begin
               if (m1_axi_rvalid) begin
                  take_r  = 1'b1;
                  state_d = is_sum ? RD_OVF : DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      if (take_r) begin
         if (m1_axi_rresp != RESP_WIDTH'(RESP_OKAY)) err_d = 1'b1;
         if (is_sum) sum_d = m1_axi_rdata;
         else ovf_d = m1_axi_rdata[0];
      end
      if (state_d != state_q) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
   end

   always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
      if (m1_axi_areset) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         sum_q     <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         sum_q     <= sum_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign error    = done && err_q;
   assign sum      = sum_q;
   assign overflow = ovf_q;

   assign m1_axi_awvalid = wr_st && !aw_done_q;
   assign m1_axi_wvalid  = wr_st && !w_done_q;
   assign m1_axi_awaddr  = (state_q == WR_B) ? ADDR_WIDTH'(ADDR_OPB)
                                             : ADDR_WIDTH'(ADDR_OPA);
   assign m1_axi_wdata   = (state_q == WR_B) ? opb_q : opa_q;
   assign m1_axi_wstrb   = '1;
   assign m1_axi_bready  = wr_st || wrb_st;
   assign m1_axi_arvalid = rd_st;
   assign m1_axi_araddr  = is_sum ? ADDR_WIDTH'(ADDR_SUM)
                                  : ADDR_WIDTH'(ADDR_OVF);
   assign m1_axi_rready  = rd_st || rdr_st;

endmodule

// File: tb/tb_adder_axi_master.sv
// Bench for adder_axi_master: reactive adder slave plus arithmetic reference.
module tb_adder_axi_master;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;
   localparam int unsigned RW = 3;
   localparam int unsigned TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] op_a = '0;
   logic [DW-1:0] op_b = '0;
   logic          busy, done, overflow, error;
   logic [DW-1:0] sum;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [RW-1:0] bresp, rresp;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;

   always #5 clk = ~clk;

   adder_axi_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .m1_axi_aclk(clk), .m1_axi_areset(rst),
      .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .sum(sum), .overflow(overflow), .error(error),
      .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
      .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid),
      .m1_axi_wready(wready), .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid),
      .m1_axi_bready(bready), .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid),
      .m1_axi_arready(arready), .m1_axi_rdata(rdata), .m1_axi_rresp(rresp),
      .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // slave configuration and observable history
   bit          cfg_rand = 0;
   bit          cfg_ar_hang = 0;
   bit          cfg_b4_err = 0;
   int          cfg_aw_delay = 0;
   logic [31:0] reg_a = '0;
   logic [31:0] reg_b = '0;
   logic [39:0] wlog[$];
   bit          slv_err = 0;
   int          aw0_hi = 0;
   int          w0_hi = 0;
   int          ar8_hi = 0;

   function automatic logic [31:0] rd_reg(input logic [7:0] ad);
      logic [32:0] s;
      s = {1'b0, reg_a} + {1'b0, reg_b};
      case (ad)
         8'h00:   return reg_a;
         8'h04:   return reg_b;
         8'h08:   return s[31:0];
         8'h0C:   return {31'd0, s[32]};
         default: return '0;
      endcase
   endfunction

   function automatic logic [2:0] rnd_rsp();
      return (cfg_rand && $urandom_range(0, 9) == 0) ? 3'd2 : 3'd0;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (awvalid && awaddr == 8'h00) aw0_hi++;
         if (wvalid && awaddr == 8'h00) w0_hi++;
         if (arvalid && araddr == 8'h08) ar8_hi++;
      end
   end

   initial begin : slave
      bit aw_hs, w_hs, b_hs, ar_hs, r_hs, awv_s;
      bit aw_got, w_got, b_pend, r_pend, r_same;
      logic [7:0]  aw_s, ar_s, aw_addr;
      logic [31:0] wd_s, w_dat, r_dat;
      logic [2:0]  b_rsp, r_rsp;
      int aw_cnt, b_cnt, r_cnt;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; r_same = 0;
      aw_cnt = 0; b_cnt = 0; r_cnt = 0; aw_addr = '0; w_dat = '0;
      r_dat = '0; b_rsp = '0; r_rsp = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      forever begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;
         ar_hs = arvalid && arready;
         r_hs  = rvalid && rready;
         awv_s = awvalid;
         aw_s  = awaddr;
         wd_s  = wdata;
         ar_s  = araddr;
         if (!rst && b_hs && bresp != '0) slv_err = 1;
         if (!rst && r_hs && rresp != '0) slv_err = 1;
         @(posedge clk);
         #1;
         if (rst) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; r_same = 0;
            aw_cnt = 0;
            awready = 0; wready = 0; bvalid = 0; bresp = '0;
            arready = 0; rvalid = 0; rdata = '0; rresp = '0;
         end else begin
            if (b_hs) b_pend = 0;
            if (r_hs) r_pend = 0;
            if (b_pend && b_cnt > 0) b_cnt--;
            if (r_pend && r_cnt > 0) r_cnt--;
            if (aw_hs) begin
               aw_got = 1; aw_addr = aw_s; aw_cnt = 0;
            end else if (awv_s) begin
               aw_cnt++;
            end
            if (w_hs) begin
               w_got = 1; w_dat = wd_s;
            end
            if (aw_got && w_got) begin
               if (aw_addr == 8'h00) reg_a = w_dat;
               else if (aw_addr == 8'h04) reg_b = w_dat;
               wlog.push_back({aw_addr, w_dat});
               aw_got = 0; w_got = 0; b_pend = 1;
               b_cnt = cfg_rand ? $urandom_range(0, 2) : 0;
               b_rsp = (cfg_b4_err && aw_addr == 8'h04) ? 3'd2 : rnd_rsp();
            end
            if (ar_hs && !r_same) begin
               r_pend = 1;
               r_cnt = cfg_rand ? $urandom_range(0, 2) : 0;
               r_dat = rd_reg(ar_s);
               r_rsp = rnd_rsp();
            end
            awready = cfg_rand ? 1'($urandom_range(0, 1)) : (aw_cnt >= cfg_aw_delay);
            wready  = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid  = b_pend && b_cnt == 0;
            bresp   = bvalid ? b_rsp : 3'd0;
            r_same  = 0;
            if (cfg_rand && arvalid && !r_pend && $urandom_range(0, 2) == 0) begin
               arready = 1; rvalid = 1; rdata = rd_reg(araddr);
               rresp = rnd_rsp(); r_same = 1;
            end else begin
               arready = (cfg_ar_hang && araddr == 8'h08) ? 1'b0 :
                         cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
               rvalid = r_pend && r_cnt == 0;
               rdata  = rvalid ? r_dat : '0;
               rresp  = rvalid ? r_rsp : 3'd0;
            end
         end
      end
   end

   function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic run_cmd(input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input int bound,
                          output int lat, output bit seen);
      wlog.delete();
      slv_err = 0; aw0_hi = 0; w0_hi = 0; ar8_hi = 0;
      op_a = a; op_b = b; start = 1;
      @(posedge clk);
      #1;
      check_eq("busy_on", 64'(busy), 64'd1);
      if (hold) begin
         op_a = $urandom; op_b = $urandom;
      end else begin
         start = 0;
      end
      lat = 0; seen = 0;
      while (!seen && lat < bound) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) seen = 1;
      end
      start = 0;
      check_eq("done_seen", 64'(seen), 64'd1);
   endtask

   task automatic end_cmd();
      @(posedge clk);
      #1;
      check_eq("busy_off", 64'({busy, done}), 64'd0);
   endtask

   task automatic check_result(input logic [31:0] a, input logic [31:0] b,
                               input bit exp_err);
      logic [32:0] r;
      logic [39:0] g0, g1;
      r = ref_add(a, b);
      check_eq("sum", 64'(sum), 64'(r[31:0]));
      check_eq("overflow", 64'(overflow), 64'(r[32]));
      check_eq("error", 64'(error), 64'(exp_err));
      check_eq("busy_at_done", 64'(busy), 64'd1);
      check_eq("wr_count", 64'(wlog.size()), 64'd2);
      g0 = (wlog.size() > 0) ? wlog[0] : '1;
      g1 = (wlog.size() > 1) ? wlog[1] : '1;
      check_eq("wr_opa", 64'(g0), 64'({8'h00, a}));
      check_eq("wr_opb", 64'(g1), 64'({8'h04, b}));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin : main
      int lat;
      bit seen;
      int k;
      logic [31:0] a, b;
      #1 rst = 1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outs", 64'({busy, done, error, awvalid, wvalid, bready,
                                  arvalid, rready, overflow, sum}), 64'd0);
      check_eq("wstrb", 64'(wstrb), 64'hF);
      @(negedge clk) rst = 0;
      @(posedge clk);
      #1;

      run_cmd(32'd5, 32'd7, 0, 200, lat, seen);
      check_eq("ideal_latency", 64'(lat), 64'd8);
      check_result(32'd5, 32'd7, 0);
      end_cmd();

      run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 200, lat, seen);
      check_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      end_cmd();

      cfg_aw_delay = 3;
      run_cmd(32'h1234, 32'h4321, 0, 200, lat, seen);
      check_eq("aw_hold_cycles", 64'(aw0_hi), 64'd4);
      check_eq("w_hold_cycles", 64'(w0_hi), 64'd1);
      check_eq("awdelay_latency", 64'(lat), 64'd14);
      check_result(32'h1234, 32'h4321, 0);
      end_cmd();
      cfg_aw_delay = 0;

      cfg_b4_err = 1;
      run_cmd(32'h8000_0000, 32'h8000_0001, 0, 200, lat, seen);
      check_result(32'h8000_0000, 32'h8000_0001, 1);
      end_cmd();
      cfg_b4_err = 0;

      cfg_ar_hang = 1;
      run_cmd(32'd3, 32'd4, 0, 300, lat, seen);
      check_eq("to_latency", 64'(lat), 64'(TO + 4));
      check_eq("to_ar_cycles", 64'(ar8_hi), 64'(TO));
      check_eq("to_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
      check_eq("to_error", 64'(error), 64'd1);
      check_eq("to_sum_held", 64'(sum), 64'd1);
      check_eq("to_ovf_held", 64'(overflow), 64'd1);
      end_cmd();

      op_a = 32'd9; op_b = 32'd10; start = 1;
      @(posedge clk);
      #1;
      start = 0;
      k = 0;
      while (!arvalid && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("reach_rd_sum", 64'(arvalid), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1;
      #1;
      check_eq("async_reset", 64'({busy, done, error, awvalid, wvalid, bready,
                                   arvalid, rready, overflow, sum}), 64'd0);
      @(negedge clk);
      cfg_ar_hang = 0;
      rst = 0;
      @(posedge clk);
      #1;
      run_cmd(32'hDEAD_0000, 32'h0000_BEEF, 0, 200, lat, seen);
      check_eq("post_reset_latency", 64'(lat), 64'd8);
      check_result(32'hDEAD_0000, 32'h0000_BEEF, 0);
      end_cmd();

      cfg_rand = 1;
      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? ~a + 32'($urandom_range(0, 2)) : $urandom;
         run_cmd(a, b, 1'($urandom_range(0, 1)), 300, lat, seen);
         check_result(a, b, slv_err);
         end_cmd();
      end
      cfg_rand = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
